// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset vector, nop encoding,
// next-PC source selection and its priority helper.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_DEFAULT = 4096;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_J,
    NPC_JR
  } npc_sel_e;

  // Redirect priority: jr > j > branch > sequential.
  function automatic npc_sel_e select_npc(input logic jr_en,
                                          input logic j_en,
                                          input logic br_en);
    if (jr_en)      return NPC_JR;
    else if (j_en)  return NPC_J;
    else if (br_en) return NPC_BR;
    else            return NPC_SEQ;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculation for the fetch stage. Purely combinational: branch and
// jump targets are formed relative to the delay-slot PC (pc_d + 4).
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic        br_en,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] pc_f_plus4;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  npc_sel_e    sel;

  assign pc_f_plus4 = pc_f + 32'd4;
  assign pc_d_plus4 = pc_d + 32'd4;
  // Word offset, sign-extended and scaled to bytes.
  assign br_offset  = {{14{br_imm[15]}}, br_imm, 2'b00};
  assign sel        = select_npc(jr_en, j_en, br_en);

  // Mux the winning redirect target; all adds wrap modulo 2^32.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    npc = pc_f_plus4;
    case (sel)
      NPC_BR:  npc = pc_d_plus4 + br_offset;
      NPC_J:   npc = {pc_d_plus4[31:28], j_index, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = pc_f_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch address to instruction memory
// and the IF/ID pipeline register. The instruction in IF when a redirect is
// resolved is the delay slot and is never squashed.
// Optional feature: define FETCH_BOUND_CHECK_EN to flag fetches that are
// misaligned or outside the text segment [RESET_PC, RESET_PC + 4*IM_DEPTH).
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_en,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        fetch_err_d
);

  logic [31:0] npc;
  logic [31:0] instr_next;

  npc_calc u_npc_calc (
    .pc_f      (pc_f),
    .pc_d      (pc_d),
    .br_en     (br_en),
    .br_imm    (br_imm),
    .j_en      (j_en),
    .j_index   (j_index),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .npc       (npc)
  );

`ifdef FETCH_BOUND_CHECK_EN
  // End of the text segment, one bit wider so the limit itself cannot wrap.
  localparam logic [32:0] TEXT_END = {1'b0, RESET_PC} + (33'(IM_DEPTH) << 2);

  logic fault_f;
  logic fetch_err_q;

  assign fault_f = (pc_f[1:0] != 2'b00) || (pc_f < RESET_PC) ||
                   ({1'b0, pc_f} >= TEXT_END);
  // A faulting fetch enters ID as a nop carrying its own PC.
  assign instr_next  = fault_f ? NOP_INSTR : instr_f;
  assign fetch_err_d = fetch_err_q;

  // Fault flag travels with the instruction and holds under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       fetch_err_q <= 1'b0;
    else if (!stall) fetch_err_q <= fault_f;
  end
`else
  assign instr_next  = instr_f;
  assign fetch_err_d = 1'b0;
`endif

  // PC and IF/ID register: advance unless the hazard unit stalls.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc_f    <= RESET_PC;
      instr_d <= NOP_INSTR;
      pc_d    <= RESET_PC;
    end else if (!stall) begin
      pc_f    <= npc;
      instr_d <= instr_next;
      pc_d    <= pc_f;
    end
  end

  assign pc8_d = pc_d + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC   = 32'h0000_3000;
  localparam logic [31:0] TEXT_TOP = 32'h0000_7000;  // 0x3000 + 4*4096

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_en;
  logic [15:0] br_imm;
  logic        j_en;
  logic [25:0] j_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        fetch_err_d;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_en       (br_en),
    .br_imm      (br_imm),
    .j_en        (j_en),
    .j_index     (j_index),
    .jr_en       (jr_en),
    .jr_target   (jr_target),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc8_d       (pc8_d),
    .fetch_err_d (fetch_err_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct nonzero word per address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  assign instr_f = imem(pc_f);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr_d, m_pc_d;
  logic        m_err;

  function automatic logic bad_fetch(input logic [31:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return (a % 4 != 0) || (a < RST_PC) || (a >= TEXT_TOP);
`else
    return 1'b0 && (a == 32'h0);
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] pcd);
    logic [31:0] slot;
    int          off;
    slot = pcd + 32'd4;
    off  = 4 * int'($signed(br_imm));
    if (jr_en)      return jr_target;
    else if (j_en)  return (slot & 32'hF000_0000) | (32'(j_index) * 4);
    else if (br_en) return slot + 32'(off);
    else            return pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc      <= RST_PC;
      m_instr_d <= 32'h0;
      m_pc_d    <= RST_PC;
      m_err     <= 1'b0;
    end else if (!stall) begin
      m_pc      <= model_next(m_pc, m_pc_d);
      m_instr_d <= bad_fetch(m_pc) ? 32'h0 : imem(m_pc);
      m_pc_d    <= m_pc;
      m_err     <= bad_fetch(m_pc);
    end
  end

  // One compare process, away from the active edge.
  always @(negedge clk) begin
    check("pc_f",        pc_f,                 m_pc);
    check("instr_d",     instr_d,              m_instr_d);
    check("pc_d",        pc_d,                 m_pc_d);
    check("pc8_d",       pc8_d,                m_pc_d + 32'd8);
    check("fetch_err_d", {31'b0, fetch_err_d}, {31'b0, m_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_en = 0; j_en = 0; jr_en = 0;
    br_imm = 16'h0; j_index = 26'h0; jr_target = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    check("init_pc_f", pc_f, 32'h3000);
    repeat (5) step();

    // 1. async reset mid-cycle while a branch is being presented
    br_en = 1; br_imm = 16'h0040;
    #2 reset = 1'b1;
    #1;
    check("t1_rst_pc_f",    pc_f,    32'h3000);
    check("t1_rst_instr_d", instr_d, 32'h0);
    check("t1_rst_pc_d",    pc_d,    32'h3000);
    step();
    reset = 1'b0;
    idle_inputs();
    check("t1_pc_f0", pc_f, 32'h3000);
    step();
    check("t1_pc_f1",    pc_f,    32'h3004);
    check("t1_instr_d1", instr_d, imem(32'h3000));
    step();
    check("t1_pc_f2",    pc_f,    32'h3008);
    check("t1_instr_d2", instr_d, imem(32'h3004));

    // 2. branch back from pc_d=0x3010, delay slot 0x3014 still lands in ID
    repeat (3) step();
    check("t2_pc_d_pre", pc_d, 32'h3010);
    br_en = 1; br_imm = 16'hFFFC;
    step();
    idle_inputs();
    check("t2_pc_f",    pc_f,    32'h3004);
    check("t2_instr_d", instr_d, imem(32'h3014));

    // 3. jr beats j; link value from pc_d=0x3020
    repeat (8) step();
    check("t3_pc_d_pre", pc_d,  32'h3020);
    check("t3_pc8_d",    pc8_d, 32'h3028);
    j_en = 1; jr_en = 1; jr_target = 32'h3100; j_index = 26'hC40;
    step();
    idle_inputs();
    check("t3_pc_f", pc_f, 32'h3100);

    // 4. three stalled cycles with a branch held, then it is taken
    stall = 1; br_en = 1; br_imm = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_pc_f",    pc_f,    32'h3100);
      check("t4_hold_pc_d",    pc_d,    32'h3024);
      check("t4_hold_instr_d", instr_d, imem(32'h3024));
    end
    stall = 0;
    step();
    idle_inputs();
    check("t4_br_pc_f", pc_f, 32'h3068);

    // 5. wrap at the top of the address space
    jr_en = 1; jr_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    check("t5_pc_f_top", pc_f, 32'hFFFF_FFFC);
    step();
    check("t5_pc_f_wrap", pc_f, 32'h0);
`ifdef FETCH_BOUND_CHECK_EN
    check("t5_err", {31'b0, fetch_err_d}, 32'h1);
`else
    check("t5_err", {31'b0, fetch_err_d}, 32'h0);
`endif

    // 6. misaligned fetch
    jr_en = 1; jr_target = 32'h3002;
    step();
    idle_inputs();
    check("t6_pc_f", pc_f, 32'h3002);
    step();
    check("t6_pc_d", pc_d, 32'h3002);
`ifdef FETCH_BOUND_CHECK_EN
    check("t6_err",     {31'b0, fetch_err_d}, 32'h1);
    check("t6_instr_d", instr_d, 32'h0);
`else
    check("t6_err",     {31'b0, fetch_err_d}, 32'h0);
    check("t6_instr_d", instr_d, imem(32'h3002));
`endif

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      stall   = ($urandom_range(0, 3) == 0);
      br_en   = ($urandom_range(0, 4) == 0);
      j_en    = ($urandom_range(0, 9) == 0);
      jr_en   = ($urandom_range(0, 7) == 0);
      br_imm  = 16'($urandom);
      j_index = 26'($urandom);
      case ($urandom_range(0, 3))
        0:       jr_target = 32'($urandom);
        1:       jr_target = RST_PC + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(0, 3));
        default: jr_target = RST_PC + 32'($urandom_range(0, 4095)) * 4;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
